// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding,
// register offsets inside the controller's bus window, and the ID width.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAISE = 2'd1,
        ST_GAP   = 2'd2
    } irq_state_t;

    localparam logic [7:0] OFF_MASK = 8'd0;
    localparam logic [7:0] OFF_PEND = 8'd1;
    localparam logic [7:0] OFF_STAT = 8'd2;

    localparam int ID_W = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
// Purely combinational and N_SRC-parameterised so other arbiters can reuse it.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx   = req[i] ? ID_W'(i) : idx;
            valid = req[i] | valid;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller on the 8-bit Micro bus.
// Registers at BASE_ADDR: +0 MASK (rw), +1 PEND (r, write-1-to-clear),
// +2 STAT (r; [2:0] last acknowledged ID, [7] acknowledge-timeout flag).
// Optional feature macro: IRQ_ACK_TIMEOUT_EN -- abandons an unacknowledged
// request after TIMEOUT cycles, leaving it pending so it is raised again.
module irq_controller
    import irq_pkg::*;
#(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter int         TIMEOUT   = 255
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_SRC,
    input  logic [7:0]       BUS_ADDR,
    input  logic [7:0]       BUS_DATA_IN,
    input  logic             BUS_WE,
    output logic [7:0]       BUS_DATA_OUT,
    output logic             BUS_DATA_OUT_EN,
    output logic             IRQ_RAISE,
    output logic [ID_W-1:0]  IRQ_ID,
    input  logic             IRQ_ACK
);

    localparam logic [7:0] ADDR_MASK = BASE_ADDR + OFF_MASK;
    localparam logic [7:0] ADDR_PEND = BASE_ADDR + OFF_PEND;
    localparam logic [7:0] ADDR_STAT = BASE_ADDR + OFF_STAT;

    logic [N_SRC-1:0] src_q_r;
    logic [N_SRC-1:0] mask_r;
    logic [N_SRC-1:0] pend_r;
    logic [N_SRC-1:0] pend_nxt_s;
    logic [N_SRC-1:0] evt_s;
    logic [N_SRC-1:0] req_s;
    logic [N_SRC-1:0] ack_sel_s;
    irq_state_t       state_r;
    logic             raise_r;
    logic [ID_W-1:0]  id_r;
    logic [ID_W-1:0]  stat_id_r;
    logic             to_flag_r;
    logic [7:0]       dout_r;
    logic             dout_en_r;
    logic [7:0]       rd_data_s;
    logic             hit_mask_s;
    logic             hit_pend_s;
    logic             hit_stat_s;
    logic             rd_s;
    logic             wr_mask_s;
    logic             wr_pend_s;
    logic             wr_stat_s;
    logic             ack_fire_s;
    logic             to_hit_s;
    logic [ID_W-1:0]  enc_idx_s;
    logic             enc_valid_s;
    logic             unused_s;

    // Upper write-data bits beyond N_SRC carry no meaning for MASK/PEND.
    assign unused_s = ^BUS_DATA_IN;

    assign hit_mask_s = (BUS_ADDR == ADDR_MASK);
    assign hit_pend_s = (BUS_ADDR == ADDR_PEND);
    assign hit_stat_s = (BUS_ADDR == ADDR_STAT);
    assign rd_s       = (hit_mask_s | hit_pend_s | hit_stat_s) & ~BUS_WE;
    assign wr_mask_s  = hit_mask_s & BUS_WE;
    assign wr_pend_s  = hit_pend_s & BUS_WE;
    assign wr_stat_s  = hit_stat_s & BUS_WE;

    assign evt_s      = IRQ_SRC & ~src_q_r;
    assign req_s      = pend_r & mask_r;
    assign ack_fire_s = (state_r == ST_RAISE) & IRQ_ACK;
    assign ack_sel_s  = N_SRC'(32'd1) << id_r;

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req   (req_s),
        .idx   (enc_idx_s),
        .valid (enc_valid_s)
    );

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r;

    // Count cycles spent in RAISE; held at zero elsewhere so each entry starts fresh.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_r <= '0;
        end else if (state_r == ST_RAISE) begin
            cnt_r <= cnt_r + CNT_W'(32'd1);
        end else begin
            cnt_r <= '0;
        end
    end

    assign to_hit_s = (state_r == ST_RAISE) & ~IRQ_ACK & (cnt_r == CNT_W'(TIMEOUT - 1));
`else
    // Without the counter the request never expires.
    assign to_hit_s = (TIMEOUT < 0);
`endif

    // Next pending vector: clears first, fresh events last so an event always wins.
    always_comb begin
        pend_nxt_s = pend_r;
        if (wr_pend_s) begin
            pend_nxt_s = pend_nxt_s & ~BUS_DATA_IN[N_SRC-1:0];
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
        if (ack_fire_s) begin
            pend_nxt_s = pend_nxt_s & ~ack_sel_s;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
        pend_nxt_s = pend_nxt_s | evt_s;
    end

    // Edge-detect history, pending latch and mask register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            src_q_r <= '0;
            pend_r  <= '0;
            mask_r  <= '0;
        end else begin
            src_q_r <= IRQ_SRC;
            pend_r  <= pend_nxt_s;
            if (wr_mask_s) begin
                mask_r <= BUS_DATA_IN[N_SRC-1:0];
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Timeout flag: set on expiry (wins over a same-cycle clear), cleared by writing 1 to STAT[7].
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            to_flag_r <= 1'b0;
        end else if (to_hit_s) begin
            to_flag_r <= 1'b1;
        end else if (wr_stat_s && BUS_DATA_IN[7]) begin
            to_flag_r <= 1'b0;
        end else begin
            to_flag_r <= to_flag_r;
        end
    end

    // Request FSM: pick the winner in IDLE, hold it through RAISE, force one low cycle in GAP.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= ST_IDLE;
            raise_r   <= 1'b0;
            id_r      <= '0;
            stat_id_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enc_valid_s) begin
                        state_r <= ST_RAISE;
                        raise_r <= 1'b1;
                        id_r    <= enc_idx_s;
                    end else begin
                        state_r <= ST_IDLE;
                        raise_r <= 1'b0;
                    end
                end
                ST_RAISE: begin
                    if (ack_fire_s) begin
                        state_r   <= ST_GAP;
                        raise_r   <= 1'b0;
                        stat_id_r <= id_r;
                    end else if (to_hit_s) begin
                        state_r <= ST_GAP;
                        raise_r <= 1'b0;
                    end else begin
                        state_r <= ST_RAISE;
                        raise_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    state_r <= ST_IDLE;
                    raise_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    raise_r <= 1'b0;
                end
            endcase
        end
    end

    // Read mux over the three registers; unused upper bits read as zero.
    always_comb begin
        rd_data_s = 8'h00;
        if (hit_mask_s) begin
            rd_data_s = 8'(mask_r);
        end else if (hit_pend_s) begin
            rd_data_s = 8'(pend_r);
        end else if (hit_stat_s) begin
            rd_data_s = {to_flag_r, 4'b0000, stat_id_r};
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Registered bus read port; the enable lasts one cycle per read.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dout_r    <= 8'h00;
            dout_en_r <= 1'b0;
        end else if (rd_s) begin
            dout_r    <= rd_data_s;
            dout_en_r <= 1'b1;
        end else begin
            dout_r    <= dout_r;
            dout_en_r <= 1'b0;
        end
    end

    assign BUS_DATA_OUT    = dout_r;
    assign BUS_DATA_OUT_EN = dout_en_r;
    assign IRQ_RAISE       = raise_r;
    assign IRQ_ID          = id_r;

endmodule
